// File: rtl/ins_fetch_unit_if.sv
// ROM read handshake between the fetch stage and instruction ROM.
// Master issues word reads; slave answers with ack plus data.
interface ins_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [15:0]       rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );
endinterface

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: PC, ROM req/ack fetch, prefetch queue.
// Optional INS_FETCH_PERF_EN adds fetch/flush performance counters.
module ins_fetch_unit #(
  parameter int ADDR_W     = 16,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ins_fetch_unit_if.master  rom,
  input  logic              Ins_ready,
  output logic              Ins_load,
  output logic [15:0]       Ins_addr,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt
`ifdef INS_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;

  logic [15:0]       word_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     count_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));

  assign rom.rom_req  = (state_q != IDLE);
  assign rom.rom_addr = req_addr_q;

  assign Ins_load = !empty && Ins_ready && !jmp_en;
  assign Ins_addr = empty ? 16'h0000 : word_mem[rd_q];
  assign pc_out   = empty ? '0 : addr_mem[rd_q];
  assign pop      = Ins_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      req_addr_q <= RST_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!halt && !jmp_en && !full) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (rom.rom_ack) begin
          state_d = IDLE;
          if (!jmp_en) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          end
        end else if (jmp_en) begin
          // read is still in flight: wait it out, drop the data
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (rom.rom_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (jmp_en) fetch_pc_d = jmp_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (jmp_en) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_q + PW'(pop);
      wr_q    <= wr_q + PW'(push);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_q] <= rom.rom_data;
      addr_mem[wr_q] <= rom.rom_addr;
    end
  end

`ifdef INS_FETCH_PERF_EN
  logic flush_ev;
  assign flush_ev = jmp_en && (!empty || state_q == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (flush_ev && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction latch/decode stage. Holds the program counter and fetches 16-bit instruction words from ROM over a req/ack handshake. Buffers fetched words in a small prefetch queue and presents one word per cycle on Ins_addr with a one-cycle Ins_load strobe. Handles jump redirects, including discard of an in-flight ROM read.

Parameters:
ADDR_W, 16, ROM word-address width; PC wraps modulo 2^ADDR_W
RESET_PC, 0, PC value after reset (ADDR_W bits)
FIFO_DEPTH, 4, prefetch queue depth in words; power of 2, >= 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rom_req  output  1  ROM read request; held until rom_ack
rom_addr  output  ADDR_W  ROM word address; stable while rom_req=1
rom_ack  input  1  ROM read complete; rom_data valid this cycle
rom_data  input  16  instruction word from ROM
Ins_ready  input  1  downstream stage can accept a word this cycle
Ins_load  output  1  word on Ins_addr is transferred this cycle
Ins_addr  output  16  instruction word at queue head (16'h0000 when empty)
pc_out  output  ADDR_W  ROM address of the word on Ins_addr
jmp_en  input  1  one-cycle redirect pulse
jmp_addr  input  ADDR_W  redirect target
halt  input  1  suppress new ROM requests

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; fetch_pc=RESET_PC; queue count=0.
  - rom_req=0; rom_addr=RESET_PC.
  - Ins_load=0; Ins_addr=0; pc_out=0.
  - Reset mid-request drops the request; the ROM must tolerate rom_req falling without ack.
- Queue: FIFO of {word, address}; count 0..FIFO_DEPTH.
- Output is combinational from the queue head:
  - Ins_load = (count!=0) & Ins_ready & ~jmp_en.
  - Pop on the clock edge where Ins_load=1.
- Latency: ack at cycle N pushes at edge N. Earliest Ins_load for that word is cycle N+1.
- Simultaneous push and pop: count unchanged. Push never occurs when full (guaranteed by the issue rule).
- FSM states:
  - IDLE: if ~halt & ~jmp_en & count<FIFO_DEPTH, go to REQ next cycle with rom_req=1 and rom_addr=fetch_pc.
  - REQ: hold rom_req and rom_addr.
    - On rom_ack & ~jmp_en: push {rom_data, rom_addr}; fetch_pc=fetch_pc+1 (wraps); go to IDLE.
    - On jmp_en & rom_ack: data dropped; go to IDLE.
    - On jmp_en & ~rom_ack: go to DISCARD; rom_req and rom_addr keep the old address.
  - DISCARD: on rom_ack, data dropped and go to IDLE. A further jmp_en in DISCARD only updates fetch_pc.
- Only one outstanding request at a time. rom_req=0 for at least one cycle between requests (IDLE cycle).
- Jump (jmp_en=1 at an edge):
  - Queue flushed (count=0); fetch_pc=jmp_addr.
  - Jump has priority over push and pop.
  - Ins_load=0 in the jmp_en cycle.
- Halt: no new requests issued. An outstanding request completes normally and the queue continues draining. Deasserting halt resumes at fetch_pc.
- Empty queue: Ins_addr=0, pc_out=0, Ins_load=0 regardless of Ins_ready.
- Full queue: FSM stays in IDLE until a pop.

Optional Feature:
INS_FETCH_PERF_EN:
- Defined: adds outputs perf_fetch_cnt[15:0] and perf_flush_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
  - perf_fetch_cnt increments on each pushed word.
  - perf_flush_cnt increments on each jmp_en edge that flushes a non-empty queue or discards an in-flight read.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=0, ROM acks 1 cycle after req, Ins_ready=1, ROM[i]=16'h1000+i -> Ins_load pulses carry 16'h1000, 16'h1001, 16'h1002 with pc_out 0, 1, 2; rom_req is 0 for one cycle between requests.
- Ins_ready=0 -> after 4 pushes rom_req stays 0; raise Ins_ready -> 4 consecutive Ins_load cycles, then refetch from address 4.
- Request to 0x0005 outstanding, jmp_en with jmp_addr=0x0040, ack 3 cycles later with 16'hDEAD -> 16'hDEAD never appears; next rom_addr=0x0040; first Ins_load has pc_out=0x0040.
- jmp_en in the same cycle as rom_ack, with 2 words queued -> both queued words and the acked word dropped; no DISCARD state; next request to jmp_addr.
- jmp_addr=0xFFFF -> fetches 0xFFFF then 0x0000 (wrap); halt=1 mid-stream -> no new rom_req, queue drains to empty.
- rst_n low while rom_req=1 and queue holds 3 words -> rom_req, Ins_load and Ins_addr reset immediately without a clock edge; after release, fetch restarts at RESET_PC.
